// File: rtl/led_blink_scheduler_if.sv
// rtl/led_blink_scheduler_if.sv - request/config/status bundle between requesters and the LED scheduler
//
// Purpose: groups the requester-facing signals of led_blink_scheduler.
// Signals:
//   req         per-requester request level
//   on_ticks    per-requester on-phase length in ticks, slice i = [i*TICK_W +: TICK_W]
//   off_ticks   per-requester off-phase length in ticks, same slicing
//   blink_count per-requester blink count, slice i = [i*CNT_W +: CNT_W]
//   grant       one-hot owner of the LED
//   done        one-cycle completion pulse to the owner
//   busy        scheduler is not idle
//   led_out     LED drive
// Modports: master = requester side, slave = scheduler side.
interface led_blink_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int TICK_W  = 8,
  parameter int CNT_W   = 4
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TICK_W-1:0] on_ticks;
  logic [NUM_REQ*TICK_W-1:0] off_ticks;
  logic [NUM_REQ*CNT_W-1:0]  blink_count;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic                      led_out;

  modport master (
    output req, on_ticks, off_ticks, blink_count,
    input  grant, done, busy, led_out
  );

  modport slave (
    input  req, on_ticks, off_ticks, blink_count,
    output grant, done, busy, led_out
  );
endinterface

// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - round-robin scheduler sharing one blinking LED between requesters
//
// Purpose: grants one requester at a time and plays its burst of blinks
// (on_ticks high, off_ticks low, blink_count times) on led_out, with one
// tick every PRESCALE clocks.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      led_blink_scheduler_if.slave (req/config in, grant/done/busy/led_out out)
module led_blink_scheduler #(
  parameter int NUM_REQ  = 3,
  parameter int PRESCALE = 4,
  parameter int TICK_W   = 8,
  parameter int CNT_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  led_blink_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               led_out;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   owner;
  logic [TICK_W-1:0]  on_lat;
  logic [TICK_W-1:0]  off_lat;
  logic [CNT_W-1:0]   cnt_lat;
  logic [PS_W-1:0]    prescaler;
  logic [TICK_W-1:0]  phase;
  logic [CNT_W-1:0]   blinks;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [TICK_W-1:0]  pick_on;
  logic [TICK_W-1:0]  pick_off;
  logic [CNT_W-1:0]   pick_cnt;
  logic               tick;
  logic [CNT_W-1:0]   blinks_nxt;

  // Round-robin search from last+1 with wrap. Walking k downward lets the
  // nearest candidate (smallest k) overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[(int'(last) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  assign pick_on    = bus.on_ticks[pick_idx*TICK_W +: TICK_W];
  assign pick_off   = bus.off_ticks[pick_idx*TICK_W +: TICK_W];
  assign pick_cnt   = bus.blink_count[pick_idx*CNT_W +: CNT_W];
  assign tick       = (prescaler == PS_W'(PRESCALE - 1));
  assign blinks_nxt = blinks + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      led_out   <= 1'b0;
      last      <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      on_lat    <= '0;
      off_lat   <= '0;
      cnt_lat   <= '0;
      prescaler <= '0;
      phase     <= '0;
      blinks    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            grant     <= NUM_REQ'(1) << pick_idx;
            // A zero phase length would never reach phase==len-1, so run it as 1.
            on_lat    <= (pick_on  == '0) ? TICK_W'(1) : pick_on;
            off_lat   <= (pick_off == '0) ? TICK_W'(1) : pick_off;
            cnt_lat   <= pick_cnt;
            prescaler <= '0;
            phase     <= '0;
            blinks    <= '0;
            if (pick_cnt == '0) begin
              state <= FIN;
              done  <= NUM_REQ'(1) << pick_idx;
            end else begin
              state   <= ON;
              led_out <= 1'b1;
            end
          end
        end

        ON, OFF: begin
          if (!bus.req[owner]) begin
            // Owner withdrew: finish now, still handing back a done pulse.
            state   <= FIN;
            led_out <= 1'b0;
            done    <= grant;
          end else if (!tick) begin
            prescaler <= prescaler + PS_W'(1);
          end else begin
            prescaler <= '0;
            if (state == ON) begin
              if (phase == on_lat - TICK_W'(1)) begin
                state   <= OFF;
                led_out <= 1'b0;
                phase   <= '0;
              end else begin
                phase <= phase + TICK_W'(1);
              end
            end else begin
              if (phase == off_lat - TICK_W'(1)) begin
                blinks <= blinks_nxt;
                phase  <= '0;
                if (blinks_nxt == cnt_lat) begin
                  state <= FIN;
                  done  <= grant;
                end else begin
                  state   <= ON;
                  led_out <= 1'b1;
                end
              end else begin
                phase <= phase + TICK_W'(1);
              end
            end
          end
        end

        FIN: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
          last  <= owner;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant;
  assign bus.done    = done;
  assign bus.busy    = (state != IDLE);
  assign bus.led_out = led_out;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb/tb_led_blink_scheduler.sv - self-checking bench for led_blink_scheduler
module tb_led_blink_scheduler;
  localparam int NUM_REQ  = 3;
  localparam int PRESCALE = 4;
  localparam int TICK_W   = 8;
  localparam int CNT_W    = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  led_blink_scheduler_if #(.NUM_REQ(NUM_REQ), .TICK_W(TICK_W), .CNT_W(CNT_W)) bus ();

  led_blink_scheduler #(
    .NUM_REQ(NUM_REQ), .PRESCALE(PRESCALE), .TICK_W(TICK_W), .CNT_W(CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Burst-level model: a burst is a timeline of cnt*(on+off)*PRESCALE cycles
  // measured from the grant cycle, followed by one finishing cycle.
  int m_owner, m_t, m_total, m_on, m_off, m_last;
  bit m_fin;

  int led_hi;
  int done_pulses;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_fin   = 1'b0;
    m_t     = 0;
    m_last  = NUM_REQ - 1;
  endtask

  task automatic model_step();
    int cnt;
    if (m_owner < 0) begin
      if (bus.req != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (m_owner < 0 && bus.req[(m_last + k) % NUM_REQ]) m_owner = (m_last + k) % NUM_REQ;
        end
        m_on  = int'(bus.on_ticks[m_owner*TICK_W +: TICK_W]);
        m_off = int'(bus.off_ticks[m_owner*TICK_W +: TICK_W]);
        cnt   = int'(bus.blink_count[m_owner*CNT_W +: CNT_W]);
        if (m_on == 0) m_on = 1;
        if (m_off == 0) m_off = 1;
        m_total = cnt * (m_on + m_off) * PRESCALE;
        m_t     = 0;
        m_fin   = (m_total == 0);
      end
    end else if (m_fin) begin
      m_last  = m_owner;
      m_owner = -1;
      m_fin   = 1'b0;
    end else if (!bus.req[m_owner]) begin
      m_fin = 1'b1;
    end else begin
      m_t++;
      if (m_t == m_total) m_fin = 1'b1;
    end
  endtask

  task automatic cycle(input int n);
    int eg, ed, el, eb;
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      if (!reset_n) model_reset();
      else model_step();
      @(negedge clock);
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      ed = m_fin ? eg : 0;
      el = (m_owner >= 0 && !m_fin &&
            (m_t % ((m_on + m_off) * PRESCALE)) < m_on * PRESCALE) ? 1 : 0;
      eb = (m_owner >= 0) ? 1 : 0;
      check_eq("grant", 32'(bus.grant), 32'(eg));
      check_eq("done", 32'(bus.done), 32'(ed));
      check_eq("led_out", 32'(bus.led_out), 32'(el));
      check_eq("busy", 32'(bus.busy), 32'(eb));
      if (bus.led_out) led_hi++;
      if (bus.done != '0) done_pulses++;
    end
  endtask

  task automatic set_cfg(input int i, input int on, input int off, input int cnt);
    bus.on_ticks[i*TICK_W +: TICK_W]   = TICK_W'(on);
    bus.off_ticks[i*TICK_W +: TICK_W]  = TICK_W'(off);
    bus.blink_count[i*CNT_W +: CNT_W]  = CNT_W'(cnt);
  endtask

  initial begin
    int exp_order [4];
    bus.req         = '0;
    bus.on_ticks    = '0;
    bus.off_ticks   = '0;
    bus.blink_count = '0;
    model_reset();
    led_hi      = 0;
    done_pulses = 0;

    cycle(2);
    reset_n = 1'b1;
    check_eq("rst_grant", 32'(bus.grant), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_led", 32'(bus.led_out), 0);

    // Reset in the middle of a burst
    set_cfg(0, 1, 1, 3);
    bus.req = 3'b001;
    done_pulses = 0;
    cycle(3);
    check_eq("t1_led_before_rst", 32'(bus.led_out), 1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("t1_async_led", 32'(bus.led_out), 0);
    check_eq("t1_async_grant", 32'(bus.grant), 0);
    check_eq("t1_async_busy", 32'(bus.busy), 0);
    check_eq("t1_async_done", 32'(bus.done), 0);
    cycle(2);
    check_eq("t1_no_done", 32'(done_pulses), 0);
    reset_n = 1'b1;
    set_cfg(1, 1, 1, 1);
    bus.req = 3'b011;
    cycle(1);
    check_eq("t1_first_grant", 32'(bus.grant), 32'd1);
    bus.req = 3'b000;
    cycle(3);

    // Single burst, on=2 off=1 count=2
    set_cfg(1, 2, 1, 2);
    bus.req = 3'b010;
    led_hi = 0;
    done_pulses = 0;
    cycle(1);
    check_eq("t2_grant", 32'(bus.grant), 32'd2);
    cycle(24);
    check_eq("t2_done", 32'(bus.done), 32'd2);
    check_eq("t2_led_cycles", 32'(led_hi), 32'd16);
    check_eq("t2_done_pulses", 32'(done_pulses), 32'd1);
    bus.req = 3'b000;
    cycle(1);
    check_eq("t2_grant_released", 32'(bus.grant), 0);

    // Round robin with all three requesting; last owner was 1
    set_cfg(0, 1, 1, 1);
    set_cfg(1, 1, 1, 1);
    set_cfg(2, 1, 1, 1);
    exp_order[0] = 4;
    exp_order[1] = 1;
    exp_order[2] = 2;
    exp_order[3] = 4;
    bus.req = 3'b111;
    for (int b = 0; b < 4; b++) begin
      cycle(1);
      check_eq("t3_rr_grant", 32'(bus.grant), 32'(exp_order[b]));
      cycle(9);
      check_eq("t3_idle_gap", 32'(bus.grant), 0);
    end
    bus.req = 3'b000;
    cycle(2);

    // Zero blink count
    set_cfg(2, 3, 3, 0);
    bus.req = 3'b100;
    led_hi = 0;
    cycle(1);
    check_eq("t4_grant", 32'(bus.grant), 32'd4);
    check_eq("t4_done", 32'(bus.done), 32'd4);
    bus.req = 3'b000;
    cycle(1);
    check_eq("t4_idle", 32'(bus.busy), 0);
    check_eq("t4_led_never", 32'(led_hi), 0);

    // Abort by owner withdrawing its request
    set_cfg(0, 5, 1, 4);
    bus.req = 3'b001;
    cycle(3);
    bus.req = 3'b000;
    cycle(1);
    check_eq("t5_abort_led", 32'(bus.led_out), 0);
    check_eq("t5_abort_done", 32'(bus.done), 32'd1);
    cycle(1);
    check_eq("t5_abort_idle", 32'(bus.busy), 0);

    // Zero on/off ticks behave as one tick
    set_cfg(1, 0, 0, 1);
    bus.req = 3'b010;
    led_hi = 0;
    done_pulses = 0;
    cycle(9);
    check_eq("t6_done", 32'(bus.done), 32'd2);
    check_eq("t6_led_cycles", 32'(led_hi), 32'd4);
    check_eq("t6_done_pulses", 32'(done_pulses), 32'd1);
    bus.req = 3'b000;
    cycle(2);

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 4) == 0) bus.req = NUM_REQ'($urandom);
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, NUM_REQ - 1), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares one blinking LED output between NUM_REQ requesters.
- Each requester asks for a burst of blinks with its own on-time, off-time and blink count.
- A round-robin arbiter grants one requester at a time. A prescaled tick generator and a blink FSM then sequence the LED for that burst.
- Sits between status/diagnostic logic and the board LED pin. It replaces a free-running blinker with scheduled bursts.

Parameters:
- NUM_REQ, 3, number of requesters (≥2).
- PRESCALE, 4, clock cycles per blink tick (≥1).
- TICK_W, 8, width of each on/off tick count.
- CNT_W, 4, width of each blink count.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level.
- on_ticks  input  NUM_REQ*TICK_W  per-requester on-phase length in ticks; slice i = bits [i*TICK_W +: TICK_W].
- off_ticks  input  NUM_REQ*TICK_W  per-requester off-phase length in ticks; same slicing.
- blink_count  input  NUM_REQ*CNT_W  per-requester number of blinks; slice i = bits [i*CNT_W +: CNT_W].
- grant  output  NUM_REQ  one-hot owner of the LED, registered.
- done  output  NUM_REQ  one-cycle completion pulse to the owner, registered.
- busy  output  1  high whenever state ≠ IDLE.
- led_out  output  1  LED drive, high during the ON phase only.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; grant=0; done=0; busy=0; led_out=0.
  - Prescaler, phase counter and blink counter = 0.
  - RR pointer last=NUM_REQ-1, so req[0] has top priority after reset.
  - Reset asserted mid-burst aborts the burst immediately. No done pulse is issued.
- FSM states: IDLE, ON, OFF, FIN.
- IDLE:
  - If req≠0, pick the first set bit searching from last+1 upward with wrap.
  - On the next edge: set grant one-hot; latch that requester's on_ticks, off_ticks and blink_count; clear all counters.
  - If the latched count=0, go to FIN (led stays 0). Otherwise go to ON with led_out=1.
  - Grant therefore appears 1 cycle after req is sampled.
- Zero tick values: on_ticks or off_ticks=0 is treated as 1 at latch time.
- Prescaler: counts 0..PRESCALE-1 in ON/OFF only. tick = (prescaler==PRESCALE-1). It is cleared on every phase entry.
- ON:
  - On tick, if phase==on-1: go to OFF, led_out=0, phase=0.
  - Otherwise on tick, phase+1.
  - ON lasts exactly on*PRESCALE cycles.
- OFF:
  - On tick, if phase==off-1: blinks+1. If blinks+1==count, go to FIN; otherwise go to ON with led_out=1. phase=0 in both cases.
  - Otherwise on tick, phase+1.
  - OFF lasts exactly off*PRESCALE cycles.
- Abort: if the granted requester's req bit is low in ON or OFF, go to FIN on the next edge with led_out=0. Other requesters cannot preempt.
- FIN (exactly 1 cycle):
  - done[owner]=1; grant stays held; busy=1.
  - Next edge: grant=0, done=0, last=owner index, state=IDLE.
- Back-to-back bursts:
  - The earliest new grant is 1 cycle after returning to IDLE (arbitration cycle in IDLE).
  - A requester still holding req after done is re-arbitrated at lowest priority.
- req, on_ticks, off_ticks and blink_count of non-owners are ignored while busy. Owner config changes mid-burst have no effect (latched).
- Invariants:
  - grant is one-hot or zero; done ⊆ grant.
  - led_out=1 implies state==ON.
  - busy==(grant≠0).

Test Plan:
1. Reset: req=001, on=1, off=1, count=3; assert reset_n low 2 cycles into ON -> led_out, grant, busy drop to 0 without waiting for a clock edge; no done pulse; after release, req=011 grants 001 first.
2. Single burst: req=010 slice1 on=2, off=1, count=2 -> grant=010 1 cycle later; led high 8, low 4, high 8, low 4 cycles; done=010 for 1 cycle; grant low next cycle.
3. Round-robin: req=111 held, each with on=1, off=1, count=1 -> grants 001, 010, 100, 001 in order; each burst 8 cycles + FIN + 1 IDLE cycle; no overlap.
4. Zero count: req=100 with count=0 -> grant=100, next cycle done=100, led_out never high, back to IDLE.
5. Abort: req=001 with on=5, count=4; drop req[0] at cycle 3 of the first ON -> next edge led_out=0 and state FIN; done=001 1 cycle; then IDLE.
6. Zero ticks: on=0, off=0, count=1 -> led high exactly 4 cycles, low 4 cycles, then done pulse.
